multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle MIPS control FSM that drives the ALU's 4-bit operation code and consumes its Zero flag.
- Sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Generates all datapath mux selects and write enables.
- Sits between the instruction register (Opcode/Funct) and the datapath (PC, memory, register file, ALU).

Parameters:
- FETCH_WAIT, 0, extra cycles FETCH holds MemRead before latching the instruction (0..15).
- MEM_WAIT, 0, extra cycles MEM_RD/MEM_WR hold the memory strobe (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Opcode  input  6  instruction bits [31:26].
- Funct  input  6  instruction bits [5:0].
- Zero  input  1  ALU zero flag.
- ALUOperation  output  4  encodings: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, XOR 0101, WORD 0110 (A+(B<<2)), LUI 1010.
- ALUSrcA  output  1  0=PC, 1=register A.
- ALUSrcB  output  2  00=register B, 01=constant 4, 10=extended immediate.
- ExtOp  output  1  1=sign-extend immediate, 0=zero-extend.
- IorD  output  1  memory address: 0=PC, 1=ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- PCWrite  output  1  PC load (unconditional or branch-qualified).
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- RegDst  output  2  00=rt, 01=rd, 10=r31.
- MemtoReg  output  2  00=ALUOut, 01=MDR, 10=PC.
- RegWrite  output  1  register file write enable.
- Illegal  output  1  one-cycle pulse when an unsupported opcode or funct is decoded.

Behaviour:
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, I_EXEC, ALU_WB, BRANCH, JUMP.
- Outputs are combinational from the state register. Exceptions: PCWrite in BRANCH also depends on Zero; ALUOperation in R_EXEC also depends on Funct.
- Any output not listed for a state is 0.
- Reset (reset=0): state and wait counter cleared to FETCH/0 immediately, mid-instruction included. Outputs equal FETCH values with IRWrite=0 and PCWrite=0 while reset is low.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOperation=ADD.
  - Held FETCH_WAIT+1 cycles; IRWrite=1, PCWrite=1, PCSource=00 on the final cycle only.
  - Then DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=10, ExtOp=1, ALUOperation=WORD (branch target into ALUOut).
  - Next state by opcode:
    - 000000 with funct in {100000, 100010, 100100, 100101, 100111, 100110} -> R_EXEC.
    - 001000/001100/001101/001110/001111 -> I_EXEC.
    - 100011/101011 -> MEM_ADDR.
    - 000100/000101 -> BRANCH.
    - 000010 -> JUMP.
    - Otherwise: Illegal=1 for this cycle, then FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00; funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 100110 XOR. Then ALU_WB with RegDst=01.
- I_EXEC: ALUSrcA=1, ALUSrcB=10.
  - addi: ADD, ExtOp=1.
  - andi/ori/xori: AND/OR/XOR, ExtOp=0.
  - lui: LUI, ExtOp=0.
  - Then ALU_WB with RegDst=00.
- ALU_WB: RegWrite=1, MemtoReg=00, RegDst as latched from the exec class. Then FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ADD. Then MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1 for MEM_WAIT+1 cycles, then MEM_WB.
- MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01. Then FETCH.
- MEM_WR: MemWrite=1, IorD=1 for MEM_WAIT+1 cycles, then FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01.
  - PCWrite = Zero for beq, !Zero for bne.
  - Then FETCH.
- JUMP: PCWrite=1, PCSource=10. Then FETCH.
- Latency with zero waits: R/I 4 cycles, lw 5, sw 4, beq/bne 3, j 3. Each wait adds 1 cycle.
- Wait counter: 4 bits, cleared on entry to each waiting state. It never wraps because the parameters are bounded to 15.

Optional Feature:
- JAL_EN defined: opcode 000011 decodes to JUMP. JUMP additionally asserts RegWrite=1, RegDst=10, MemtoReg=10, writing PC+4 to r31. Latency 3.
- JAL_EN undefined: opcode 000011 is illegal (Illegal pulse, return to FETCH).

Test Plan:
- add, Funct=100000, waits 0 -> FETCH, DECODE(WORD), R_EXEC(ALUOperation=0011), ALU_WB(RegWrite=1, RegDst=01), back in FETCH on cycle 5.
- lw, MEM_WAIT=2 -> MEM_RD holds MemRead=1, IorD=1 exactly 3 cycles; MEM_WB has MemtoReg=01; total 7 cycles.
- beq with Zero=1 -> PCWrite=1, PCSource=01, ALUOperation=0100. bne with Zero=1 -> PCWrite=0.
- lui -> I_EXEC drives ALUOperation=1010, ALUSrcB=10, ExtOp=0.
- Opcode 111111, and separately R-type Funct=000000 -> Illegal high for exactly 1 cycle in DECODE, no RegWrite/MemWrite, next state FETCH.
- reset low during MEM_WR -> MemWrite drops immediately; after release FETCH runs with IRWrite only after FETCH_WAIT+1 cycles.
- Opcode 000011 -> with JAL_EN: JUMP writes RegDst=10, MemtoReg=10, RegWrite=1. Without JAL_EN: Illegal pulse.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multicycle MIPS control FSM. Sequences fetch, decode, execute, memory
//   and writeback for one instruction at a time and drives every datapath
//   mux select, write enable and the 4-bit ALU operation code.
//
// Parameters
//   FETCH_WAIT : extra cycles FETCH holds MemRead before the IR load (0..15)
//   MEM_WAIT   : extra cycles MEM_RD/MEM_WR hold the memory strobe (0..15)
//
// Optional build macro
//   JAL_EN     : when defined, opcode 000011 (jal) decodes to JUMP and also
//                writes PC+4 into r31. When undefined, jal is illegal.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   Opcode[5:0]   in   instruction bits [31:26] (held by the IR)
//   Funct[5:0]    in   instruction bits [5:0]
//   Zero          in   ALU zero flag
//   ALUOperation  out  AND 0000 OR 0001 NOR 0010 ADD 0011 SUB 0100
//                      XOR 0101 WORD 0110 (A+(B<<2)) LUI 1010
//   ALUSrcA       out  0=PC 1=register A
//   ALUSrcB[1:0]  out  00=B 01=const 4 10=extended immediate
//   ExtOp         out  1=sign-extend 0=zero-extend
//   IorD          out  memory address 0=PC 1=ALUOut
//   MemRead       out  memory read strobe
//   MemWrite      out  memory write strobe
//   IRWrite       out  instruction register load
//   PCWrite       out  PC load (branch-qualified in BRANCH)
//   PCSource[1:0] out  00=ALU result 01=ALUOut 10=jump target
//   RegDst[1:0]   out  00=rt 01=rd 10=r31
//   MemtoReg[1:0] out  00=ALUOut 01=MDR 10=PC
//   RegWrite      out  register file write enable
//   Illegal       out  one-cycle pulse on an unsupported opcode/funct

module multicycle_control #(
  parameter int unsigned FETCH_WAIT = 0,
  parameter int unsigned MEM_WAIT   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [3:0] ALUOperation,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    R_EXEC,
    I_EXEC,
    ALU_WB,
    BRANCH,
    JUMP
  } state_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_NOR  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_WORD = 4'b0110;
  localparam logic [3:0] ALU_LUI  = 4'b1010;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_XOR   = 6'b100110;

  // Last counter value of each waiting state; parameters are bounded to 15.
  localparam logic [3:0] FETCH_LAST = 4'(FETCH_WAIT);
  localparam logic [3:0] MEM_LAST   = 4'(MEM_WAIT);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [1:0] regdst_q, regdst_next;

  logic [3:0] r_op;
  logic       r_ok;

  // R-type funct decode, shared by DECODE (legality) and R_EXEC (ALU op).
  always_comb begin
    r_op = ALU_ADD;
    r_ok = 1'b1;
    case (Funct)
      FN_ADD:  r_op = ALU_ADD;
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_NOR:  r_op = ALU_NOR;
      FN_XOR:  r_op = ALU_XOR;
      default: r_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      cnt      <= '0;
      regdst_q <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      regdst_q <= regdst_next;
    end
  end

  // cnt_next defaults to zero so every waiting state is entered with a
  // cleared counter; it only advances while a state holds itself.
  always_comb begin
    state_next   = state;
    cnt_next     = '0;
    regdst_next  = regdst_q;

    ALUOperation = ALU_AND;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ExtOp        = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCSource     = 2'b00;
    RegDst       = 2'b00;
    MemtoReg     = 2'b00;
    RegWrite     = 1'b0;
    Illegal      = 1'b0;

    case (state)
      FETCH: begin
        MemRead      = 1'b1;
        ALUSrcB      = 2'b01;
        ALUOperation = ALU_ADD;
        if (cnt == FETCH_LAST) begin
          // The register is already FETCH/0 while reset is held, so the
          // load strobes are qualified by reset to keep PC/IR untouched.
          IRWrite    = reset;
          PCWrite    = reset;
          state_next = DECODE;
        end else begin
          cnt_next   = cnt + 4'd1;
        end
      end

      DECODE: begin
        ALUSrcB      = 2'b10;
        ExtOp        = 1'b1;
        ALUOperation = ALU_WORD;
        case (Opcode)
          OP_RTYPE: begin
            if (r_ok) begin
              state_next = R_EXEC;
            end else begin
              Illegal    = 1'b1;
              state_next = FETCH;
            end
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_next = I_EXEC;
          OP_LW, OP_SW:                              state_next = MEM_ADDR;
          OP_BEQ, OP_BNE:                            state_next = BRANCH;
          OP_J:                                      state_next = JUMP;
`ifdef JAL_EN
          OP_JAL:                                    state_next = JUMP;
`endif
          default: begin
            Illegal    = 1'b1;
            state_next = FETCH;
          end
        endcase
      end

      R_EXEC: begin
        ALUSrcA      = 1'b1;
        ALUOperation = r_op;
        regdst_next  = 2'b01;
        state_next   = ALU_WB;
      end

      I_EXEC: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        regdst_next = 2'b00;
        state_next  = ALU_WB;
        case (Opcode)
          OP_ANDI: ALUOperation = ALU_AND;
          OP_ORI:  ALUOperation = ALU_OR;
          OP_XORI: ALUOperation = ALU_XOR;
          OP_LUI:  ALUOperation = ALU_LUI;
          default: begin
            ALUOperation = ALU_ADD;
            ExtOp        = 1'b1;
          end
        endcase
      end

      ALU_WB: begin
        RegWrite   = 1'b1;
        RegDst     = regdst_q;
        state_next = FETCH;
      end

      MEM_ADDR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ExtOp        = 1'b1;
        ALUOperation = ALU_ADD;
        state_next   = (Opcode == OP_SW) ? MEM_WR : MEM_RD;
      end

      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (cnt == MEM_LAST) state_next = MEM_WB;
        else                 cnt_next   = cnt + 4'd1;
      end

      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'b01;
        state_next = FETCH;
      end

      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (cnt == MEM_LAST) state_next = FETCH;
        else                 cnt_next   = cnt + 4'd1;
      end

      BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUOperation = ALU_SUB;
        PCSource     = 2'b01;
        PCWrite      = (Opcode == OP_BNE) ? ~Zero : Zero;
        state_next   = FETCH;
      end

      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        state_next = FETCH;
`ifdef JAL_EN
        if (Opcode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
`endif
      end

      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed instruction sequence with a
// per-cycle expected-output scoreboard checked on the falling clock edge.
module tb_multicycle_control;

  localparam int unsigned FW = 1;
  localparam int unsigned MW = 2;

  typedef struct packed {
    logic [3:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       extop;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       illegal;
  } ctl_t;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic [3:0] ALUOperation;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtOp;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       RegWrite;
  logic       Illegal;

  multicycle_control #(.FETCH_WAIT(FW), .MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .ALUOperation(ALUOperation), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtOp(ExtOp), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Illegal(Illegal)
  );

  ctl_t act;
  assign act = {ALUOperation, ALUSrcA, ALUSrcB, ExtOp, IorD, MemRead, MemWrite,
                IRWrite, PCWrite, PCSource, RegDst, MemtoReg, RegWrite, Illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctl_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    pend     = 0;

  // Expected outputs of each state, written straight from the state table.
  function automatic ctl_t c_fetch(bit last);
    ctl_t c = '0;
    c.memread = 1'b1; c.srcb = 2'b01; c.aluop = 4'b0011;
    if (last) begin c.irwrite = 1'b1; c.pcwrite = 1'b1; end
    return c;
  endfunction
  function automatic ctl_t c_decode(bit ill);
    ctl_t c = '0;
    c.srcb = 2'b10; c.extop = 1'b1; c.aluop = 4'b0110; c.illegal = ill;
    return c;
  endfunction
  function automatic ctl_t c_rexec(logic [3:0] op);
    ctl_t c = '0;
    c.srca = 1'b1; c.aluop = op;
    return c;
  endfunction
  function automatic ctl_t c_iexec(logic [3:0] op, bit ext);
    ctl_t c = '0;
    c.srca = 1'b1; c.srcb = 2'b10; c.aluop = op; c.extop = ext;
    return c;
  endfunction
  function automatic ctl_t c_aluwb(logic [1:0] rd);
    ctl_t c = '0;
    c.regwrite = 1'b1; c.regdst = rd;
    return c;
  endfunction
  function automatic ctl_t c_memaddr();
    ctl_t c = '0;
    c.srca = 1'b1; c.srcb = 2'b10; c.extop = 1'b1; c.aluop = 4'b0011;
    return c;
  endfunction
  function automatic ctl_t c_memrd();
    ctl_t c = '0;
    c.memread = 1'b1; c.iord = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_memwb();
    ctl_t c = '0;
    c.regwrite = 1'b1; c.memtoreg = 2'b01;
    return c;
  endfunction
  function automatic ctl_t c_memwr();
    ctl_t c = '0;
    c.memwrite = 1'b1; c.iord = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_branch(bit pcw);
    ctl_t c = '0;
    c.srca = 1'b1; c.aluop = 4'b0100; c.pcsrc = 2'b01; c.pcwrite = pcw;
    return c;
  endfunction
  function automatic ctl_t c_jump(bit link);
    ctl_t c = '0;
    c.pcwrite = 1'b1; c.pcsrc = 2'b10;
    if (link) begin c.regwrite = 1'b1; c.regdst = 2'b10; c.memtoreg = 2'b10; end
    return c;
  endfunction

  task automatic push(string n, ctl_t c);
    exp_q.push_back(c);
    name_q.push_back(n);
    pend++;
  endtask

  // Starts an instruction from FETCH: drives the IR fields and queues the
  // FW+1 fetch cycles.
  task automatic start(string n, logic [5:0] op, logic [5:0] fn, logic z);
    Opcode = op; Funct = fn; Zero = z;
    pend = 0;
    for (int unsigned i = 0; i <= FW; i++) push({n, "_fetch"}, c_fetch(i == FW));
  endtask

  // Lets the queued cycles elapse; returns 1ns after the edge that should
  // land the FSM back in FETCH (or wherever the caller intervenes).
  task automatic finish();
    repeat (pend) @(posedge clk);
    #1;
  endtask

  task automatic do_r(string n, logic [5:0] fn, logic [3:0] op);
    start(n, 6'b000000, fn, 1'b0);
    push({n, "_dec"}, c_decode(1'b0));
    push({n, "_exec"}, c_rexec(op));
    push({n, "_wb"}, c_aluwb(2'b01));
    finish();
  endtask

  task automatic do_i(string n, logic [5:0] opc, logic [3:0] op, bit ext);
    start(n, opc, 6'b000000, 1'b0);
    push({n, "_dec"}, c_decode(1'b0));
    push({n, "_exec"}, c_iexec(op, ext));
    push({n, "_wb"}, c_aluwb(2'b00));
    finish();
  endtask

  task automatic do_br(string n, logic [5:0] opc, logic z, bit pcw);
    start(n, opc, 6'b000000, z);
    push({n, "_dec"}, c_decode(1'b0));
    push({n, "_br"}, c_branch(pcw));
    finish();
  endtask

  task automatic do_illegal(string n, logic [5:0] opc, logic [5:0] fn);
    start(n, opc, fn, 1'b0);
    push({n, "_dec"}, c_decode(1'b1));
    finish();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ctl_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, e, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; Opcode = '0; Funct = '0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pend = 0;
    push("rst_idle", c_fetch(1'b0));
    finish();
    reset = 1'b1;

    do_r("add", 6'b100000, 4'b0011);
    do_r("sub", 6'b100010, 4'b0100);
    do_r("and", 6'b100100, 4'b0000);
    do_i("addi", 6'b001000, 4'b0011, 1'b1);
    do_r("or",  6'b100101, 4'b0001);
    do_r("nor", 6'b100111, 4'b0010);
    do_i("andi", 6'b001100, 4'b0000, 1'b0);
    do_r("xor", 6'b100110, 4'b0101);
    do_i("ori",  6'b001101, 4'b0001, 1'b0);
    do_i("xori", 6'b001110, 4'b0101, 1'b0);
    do_i("lui",  6'b001111, 4'b1010, 1'b0);

    start("lw", 6'b100011, 6'b000000, 1'b0);
    push("lw_dec", c_decode(1'b0));
    push("lw_addr", c_memaddr());
    for (int unsigned i = 0; i <= MW; i++) push("lw_rd", c_memrd());
    push("lw_wb", c_memwb());
    finish();

    start("sw", 6'b101011, 6'b000000, 1'b0);
    push("sw_dec", c_decode(1'b0));
    push("sw_addr", c_memaddr());
    for (int unsigned i = 0; i <= MW; i++) push("sw_wr", c_memwr());
    finish();

    do_br("beq_z1", 6'b000100, 1'b1, 1'b1);
    do_br("beq_z0", 6'b000100, 1'b0, 1'b0);
    do_br("bne_z1", 6'b000101, 1'b1, 1'b0);
    do_br("bne_z0", 6'b000101, 1'b0, 1'b1);

    start("j", 6'b000010, 6'b000000, 1'b0);
    push("j_dec", c_decode(1'b0));
    push("j_jump", c_jump(1'b0));
    finish();

    do_illegal("ill_op", 6'b111111, 6'b000000);
    do_illegal("ill_fn", 6'b000000, 6'b000000);

`ifdef JAL_EN
    start("jal", 6'b000011, 6'b000000, 1'b0);
    push("jal_dec", c_decode(1'b0));
    push("jal_jump", c_jump(1'b1));
    finish();
`else
    do_illegal("jal_ill", 6'b000011, 6'b000000);
`endif

    // sw interrupted by reset in its second MEM_WR cycle: the reset is
    // applied just after the clock edge, so only an asynchronous clear can
    // make the next falling-edge sample show FETCH values.
    start("swr", 6'b101011, 6'b000000, 1'b0);
    push("swr_dec", c_decode(1'b0));
    push("swr_addr", c_memaddr());
    push("swr_wr", c_memwr());
    finish();
    reset = 1'b0;
    pend = 0;
    push("rst_mid", c_fetch(1'b0));
    push("rst_hold", c_fetch(1'b0));
    finish();
    reset = 1'b1;

    do_r("add_after", 6'b100000, 4'b0011);
    do_i("addi_end", 6'b001000, 4'b0011, 1'b1);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
